// File: rtl/clk_period_meter.sv
// Measures the rise-to-rise period and the high time of an asynchronous
// slow signal in units of I_CLK cycles, and flags loss of the signal.
module clk_period_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1000
) (
  input  logic             I_CLK,
  input  logic             I_RST_N,
  input  logic             I_EN,
  input  logic             I_SIG,
  output logic [CNT_W-1:0] O_PERIOD,
  output logic [CNT_W-1:0] O_HIGH,
  output logic             O_VALID,
  output logic             O_LOST
);

  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_MEAS   = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise_c;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_d, high_d;
  logic             valid_d, lost_d;

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise_c = s & ~s_d;

  // Synchroniser chain and edge-detect register; free-running regardless of I_EN.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I_SIG};
      s_d    <= s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      O_PERIOD <= '0;
      O_HIGH   <= '0;
      O_VALID  <= 1'b0;
      O_LOST   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      O_PERIOD <= period_d;
      O_HIGH   <= high_d;
      O_VALID  <= valid_d;
      O_LOST   <= lost_d;
    end
  end

  // Next-state and next-output logic; a rise always wins over the timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = O_PERIOD;
    high_d   = O_HIGH;
    valid_d  = 1'b0;
    lost_d   = O_LOST;

    if (!I_EN) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
      lost_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_c) begin
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = ST_MEAS;
          end
        end
        ST_MEAS: begin
          if (rise_c) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            lost_d   = 1'b0;
            cnt_d    = CNT_ONE;
            hcnt_d   = CNT_ONE;
          end else if (cnt_q == CNT_LIMIT) begin
            lost_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d  = cnt_q + CNT_ONE;
            hcnt_d = hcnt_q + CNT_W'(s);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomised bench for clk_period_meter: two instances (default build and a
// short-timeout, deeper-sync build) share one stimulus stream and are compared
// every cycle against a timestamp-based reference model.
module tb_clk_period_meter;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned NCYC  = 16000;
  localparam int unsigned S0    = 2;
  localparam int unsigned T0    = 1000;
  localparam int unsigned S1    = 3;
  localparam int unsigned T1    = 50;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             sig;
  logic [CNT_W-1:0] per0, high0, per1, high1;
  logic             val0, lost0, val1, lost1;

  always #5 clk = ~clk;

  clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(S0), .TIMEOUT(T0)) dut0 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_EN(en), .I_SIG(sig),
    .O_PERIOD(per0), .O_HIGH(high0), .O_VALID(val0), .O_LOST(lost0)
  );

  clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(S1), .TIMEOUT(T1)) dut1 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_EN(en), .I_SIG(sig),
    .O_PERIOD(per1), .O_HIGH(high1), .O_VALID(val1), .O_LOST(lost1)
  );

  int vectors;
  int miscompares;

  // hist[k] is the I_SIG value sampled by clock edge k.
  bit hist [0:NCYC+8];
  bit pend [$];

  // Reference model state, per instance.
  bit armed  [2];
  int t_last [2];
  int e_per  [2];
  int e_high [2];
  bit e_val  [2];
  bit e_lost [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic bit sh(input int idx);
    return (idx < 0) ? 1'b0 : hist[idx];
  endfunction

  task automatic check_dut(input int d);
    if (d == 0) begin
      check_eq("period0", 32'(per0),  32'(e_per[0]));
      check_eq("high0",   32'(high0), 32'(e_high[0]));
      check_eq("valid0",  32'(val0),  32'(e_val[0]));
      check_eq("lost0",   32'(lost0), 32'(e_lost[0]));
    end else begin
      check_eq("period1", 32'(per1),  32'(e_per[1]));
      check_eq("high1",   32'(high1), 32'(e_high[1]));
      check_eq("valid1",  32'(val1),  32'(e_val[1]));
      check_eq("lost1",   32'(lost1), 32'(e_lost[1]));
    end
  endtask

  task automatic model_clear(input int d);
    armed[d]  = 1'b0;
    t_last[d] = 0;
    e_per[d]  = 0;
    e_high[d] = 0;
    e_val[d]  = 1'b0;
    e_lost[d] = 1'b0;
  endtask

  // Outputs after edge k+1, given the synchronised signal during cycle k.
  // Synchronised level in cycle c is the sample taken SYNC_STAGES-1 edges earlier.
  task automatic model_step(input int d, input int k, input bit en_k);
    int sn;
    int to;
    int h;
    bit s_k;
    bit s_p;
    sn  = (d == 0) ? int'(S0) : int'(S1);
    to  = (d == 0) ? int'(T0) : int'(T1);
    s_k = sh(k - sn + 1);
    s_p = sh(k - sn);
    e_val[d] = 1'b0;
    if (!en_k) begin
      armed[d]  = 1'b0;
      e_lost[d] = 1'b0;
    end else if (s_k && !s_p) begin
      if (armed[d]) begin
        h = 0;
        for (int c = t_last[d]; c < k; c++) h += int'(sh(c - sn + 1));
        e_per[d]  = k - t_last[d];
        e_high[d] = h;
        e_val[d]  = 1'b1;
        e_lost[d] = 1'b0;
      end
      armed[d]  = 1'b1;
      t_last[d] = k;
    end else if (armed[d] && (k - t_last[d] == to)) begin
      e_lost[d] = 1'b1;
      armed[d]  = 1'b0;
    end
  endtask

  task automatic push_seg(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) pend.push_back(1'b1);
      for (int i = 0; i < lo; i++) pend.push_back(1'b0);
    end
  endtask

  // Picks the next waveform segment: random, directed periods and timeout boundaries.
  task automatic gen_seg();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 30)      push_seg(int'($urandom_range(1, 25)), int'($urandom_range(1, 25)), 1);
    else if (r < 45) push_seg(10, 10, 3);
    else if (r < 55) push_seg(3, 7, 3);
    else if (r < 65) push_seg(1, 1, 4);
    else if (r < 75) push_seg(1, int'(T1) - 1, 2);
    else if (r < 82) push_seg(1, int'(T1), 2);
    else if (r < 88) push_seg(int'($urandom_range(1, 40)), int'(T0) - 40, 1);
    else if (r < 91) push_seg(1, int'(T0) - 1, 2);
    else if (r < 94) push_seg(1, int'(T0), 1);
    else             push_seg(0, int'($urandom_range(1010, 1200)), 1);
  endtask

  // Asynchronous reset between clock edges; outputs must clear without an edge.
  task automatic do_reset(input int k);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) model_clear(d);
    check_dut(0);
    check_dut(1);
    rst_n = 1'b1;
    #1;
    for (int i = k - 3; i <= k; i++) if (i >= 0) hist[i] = 1'b0;
  endtask

  initial begin
    int en_off;
    vectors     = 0;
    miscompares = 0;
    en_off      = 0;
    rst_n       = 1'b0;
    en          = 1'b0;
    sig         = 1'b0;
    for (int d = 0; d < 2; d++) model_clear(d);
    #2;
    check_dut(0);
    check_dut(1);
    #10 rst_n = 1'b1;

    for (int k = 0; k < int'(NCYC); k++) begin
      @(posedge clk);
      #1;
      check_dut(0);
      check_dut(1);
      if (k == 4000 || $urandom_range(0, 1999) == 0) do_reset(k);

      if (en_off > 0) begin
        en_off--;
        en = 1'b0;
      end else if (k == 3000 || $urandom_range(0, 299) == 0) begin
        en_off = 4;
        en     = 1'b0;
      end else begin
        en = 1'b1;
      end

      if (pend.size() == 0) gen_seg();
      sig         = pend.pop_front();
      hist[k + 1] = sig;

      model_step(0, k, en);
      model_step(1, k, en);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
